mix_columns_iter: RTL and testbench
===================================

MIX_COLUMNS_ITER -- requirements
Module: mix_columns_iter

Interface
REQ-001 The block SHALL have parameter COLS_PER_CYCLE, default 1, columns transformed per processing cycle; legal values 1, 2, 4.
REQ-002 The block SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1, input state offered.
REQ-005 The block SHALL have port in_ready, output, 1, block can accept a state.
REQ-006 The block SHALL have port in_data, input, 128, AES state; byte s[r][c] at bits [127-8*(4r+c) -: 8], row-major.
REQ-007 The block SHALL have port in_inv, input, 1, 0 = MixColumns, 1 = InvMixColumns.
REQ-008 The block SHALL have port out_valid, output, 1, result available.
REQ-009 The block SHALL have port out_ready, input, 1, consumer accepts result.
REQ-010 The block SHALL have port out_data, output, 128, transformed state, same byte layout as in_data.
REQ-011 The block SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, BUSY, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-013 An input handshake (in_valid && in_ready) SHALL load in_data into the state register, latch in_inv, clear the beat counter, and enter BUSY.
REQ-014 In BUSY, each edge SHALL replace columns [beat*COLS_PER_CYCLE .. +COLS_PER_CYCLE-1] in place with their transform, then increment beat.
REQ-015 BUSY SHALL last N = 4/COLS_PER_CYCLE cycles; on the edge that processes the last beat the FSM SHALL enter DONE.
REQ-016 out_valid SHALL first rise N+1 edges after the accepting edge (latency N+1 edges; throughput one state per N+2 cycles at out_ready=1).
REQ-017 Forward transform SHALL use the circulant matrix rows {02,03,01,01}; inverse SHALL use {0e,0b,0d,09}; each row rotated right by one for the next row; GF(2^8) modulus 0x11B.
REQ-018 Output byte s'[r][c] SHALL equal XOR over k of M[r][k]·s[k][c].
REQ-019 In DONE, out_data SHALL hold stable until out_ready; on out_valid && out_ready the FSM SHALL return to IDLE.
REQ-020 in_data and in_inv SHALL be ignored outside the accepting cycle; changes during BUSY/DONE SHALL not affect the result.
REQ-021 out_data SHALL expose the state register directly; unprocessed columns are visible during BUSY but carry no meaning while out_valid=0.
REQ-022 An illegal COLS_PER_CYCLE SHALL cause an elaboration-time error.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, beat=0, state register=0, latched mode=0; hence in_ready=1, out_valid=0, busy=0, out_data=0.
REQ-024 Reset asserted mid-BUSY or mid-DONE SHALL discard the in-flight state with no output handshake.
REQ-025 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-026 The shared package aes_pkg SHALL hold the forward and inverse matrix coefficient constants, the 4x4 byte state typedef, and the FSM state enum.
REQ-027 One sub-module mix_single_column (32-bit column in, inv in, 32-bit column out, combinational, built on existing gf_mul) SHALL be instantiated COLS_PER_CYCLE times.

Verification
REQ-028 Forward: column 0 = db,13,53,45 (s[0..3][0]) -> s'[0..3][0] = 8e,4d,a1,bc; column 1 = f2,0a,22,5c -> 9f,dc,58,9d.
REQ-029 Inverse: column 8e,4d,a1,bc with in_inv=1 -> db,13,53,45; forward-then-inverse of 1000 random states returns the original.
REQ-030 Fixed points: all-01 and all-c6 columns unchanged in both modes; d4,d4,d4,d5 -> d5,d5,d7,d6 forward.
REQ-031 For COLS_PER_CYCLE 1, 2, 4: out_valid rises exactly 5, 3, 2 edges after acceptance; in_ready=0 throughout BUSY/DONE.
REQ-032 Hold out_ready=0 for 10 cycles in DONE -> out_data stable, no new acceptance; toggle in_data/in_inv meanwhile -> result unchanged.
REQ-033 Assert rst_n low at beat 1 of BUSY -> all outputs at reset values the same cycle; next state accepted processes correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: MixColumns coefficient rows, the 4x4 byte state view,
// the iterator FSM encoding and the GF(2^8) multiplier.
package aes_pkg;

  // First matrix row; row r is this row rotated right by r.
  localparam logic [0:3][7:0] FwdCoef = {8'h02, 8'h03, 8'h01, 8'h01};
  localparam logic [0:3][7:0] InvCoef = {8'h0e, 8'h0b, 8'h0d, 8'h09};

  // s[r][c] lands at bits [127-8*(4r+c) -: 8] when viewed as 128 bits.
  typedef logic [0:3][0:3][7:0] state_t;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} fsm_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational (Inv)MixColumns of one 32-bit column; byte s[0] in bits [31:24].
module mix_single_column
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  input  logic        inv_i,
  output logic [31:0] col_o
);

  logic [0:3][7:0] row;

  always_comb begin
    row   = inv_i ? InvCoef : FwdCoef;
    col_o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        col_o[31-8*r -: 8] ^= gf_mul(row[2'(k - r)], col_i[31-8*k -: 8]);
      end
    end
  end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative MixColumns/InvMixColumns over a 128-bit AES state, transforming
// COLS_PER_CYCLE columns in place per cycle with valid/ready handshakes.
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int unsigned Beats    = 4 / COLS_PER_CYCLE;
  localparam logic [1:0]  LastBeat = 2'(Beats - 1);

  fsm_e       fsm_q, fsm_d;
  state_t     state_q, state_d;
  logic       inv_q, inv_d;
  logic [1:0] beat_q, beat_d;

  logic [1:0]  col_idx [COLS_PER_CYCLE];
  logic [31:0] col_in  [COLS_PER_CYCLE];
  logic [31:0] col_out [COLS_PER_CYCLE];

  always_comb begin
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      col_idx[g] = 2'(32'(beat_q) * COLS_PER_CYCLE + 32'(g));
      col_in[g]  = {state_q[0][col_idx[g]], state_q[1][col_idx[g]],
                    state_q[2][col_idx[g]], state_q[3][col_idx[g]]};
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    mix_single_column u_col (
      .col_i (col_in[g]),
      .inv_i (inv_q),
      .col_o (col_out[g])
    );
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    inv_d   = inv_q;
    beat_d  = beat_q;
    unique case (fsm_q)
      StIdle: begin
        if (in_valid) begin
          state_d = in_data;
          inv_d   = in_inv;
          beat_d  = '0;
          fsm_d   = StBusy;
        end
      end
      StBusy: begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          for (int r = 0; r < 4; r++) begin
            state_d[r][col_idx[g]] = col_out[g][31-8*r -: 8];
          end
        end
        beat_d = beat_q + 2'd1;
        if (beat_q == LastBeat) fsm_d = StDone;
      end
      StDone: begin
        if (out_ready) fsm_d = StIdle;
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= StIdle;
      state_q <= '0;
      inv_q   <= 1'b0;
      beat_q  <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      inv_q   <= inv_d;
      beat_q  <= beat_d;
    end
  end

  assign in_ready  = (fsm_q == StIdle);
  assign out_valid = (fsm_q == StDone);
  assign busy      = (fsm_q != StIdle);
  assign out_data  = state_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Self-checking bench: three instances (1, 2 and 4 columns per cycle) driven in
// lockstep and compared against a polynomial-arithmetic MixColumns model.
module tb_mix_columns_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_inv;
  logic         out_ready;
  logic [2:0]   in_ready_w;
  logic [2:0]   out_valid_w;
  logic [2:0]   busy_w;
  logic [127:0] out_data_w [3];

  mix_columns_iter #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid_w[0]),
    .out_ready(out_ready), .out_data(out_data_w[0]), .busy(busy_w[0])
  );
  mix_columns_iter #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid_w[1]),
    .out_ready(out_ready), .out_data(out_data_w[1]), .busy(busy_w[1])
  );
  mix_columns_iter #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid_w[2]),
    .out_ready(out_ready), .out_data(out_data_w[2]), .busy(busy_w[2])
  );

  localparam int Cols [3] = '{1, 2, 4};

  int n_checks = 0;
  int n_pass   = 0;

  logic [127:0] got [3];
  int           lat [3];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Carry-less product followed by long division by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p ^= (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
    logic [7:0]   base [4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc ^= gmul(base[(k - r + 4) % 4], s[127-8*(4*k+c) -: 8]);
        res[127-8*(4*r+c) -: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] make_state(input logic [31:0] c0, input logic [31:0] c1,
                                              input logic [31:0] c2, input logic [31:0] c3);
    logic [31:0]  cols [4];
    logic [127:0] s;
    cols = '{c0, c1, c2, c3};
    s = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[127-8*(4*r+c) -: 8] = cols[c][31-8*r -: 8];
    return s;
  endfunction

  function automatic logic [31:0] get_col(input logic [127:0] s, input int c);
    logic [31:0] v;
    for (int r = 0; r < 4; r++) v[31-8*r -: 8] = s[127-8*(4*r+c) -: 8];
    return v;
  endfunction

  // Called at a negedge with out_ready=1; lat counts edges including the accepting one.
  task automatic run_txn(input logic [127:0] data, input logic inv);
    logic [127:0] exp_v;
    exp_v = ref_mix(data, inv);
    for (int d = 0; d < 3; d++) lat[d] = 0;
    in_valid = 1'b1;
    in_data  = data;
    in_inv   = inv;
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_after_accept", {in_ready_w, busy_w}, {3'b000, 3'b111});
    for (int e = 1; e <= 7; e++) begin
      in_data = rand128();
      in_inv  = 1'($urandom);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (out_valid_w[d] && lat[d] == 0) begin
          lat[d] = e + 1;
          got[d] = out_data_w[d];
        end
        if (e <= 4 / Cols[d])
          check($sformatf("in_ready_low_c%0d", Cols[d]), in_ready_w[d], 1'b0);
      end
    end
    for (int d = 0; d < 3; d++) begin
      check($sformatf("latency_c%0d", Cols[d]), lat[d], 4 / Cols[d] + 1);
      check($sformatf("result_c%0d", Cols[d]), got[d], exp_v);
    end
    check("idle_after_txn", {in_ready_w, busy_w}, {3'b111, 3'b000});
  endtask

  logic [127:0] st;
  logic [127:0] fwd;
  logic [127:0] exp_s;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_inv    = 1'b0;
    out_ready = 1'b1;
    #1;
    check("reset_ctrl", {in_ready_w, out_valid_w, busy_w}, {3'b111, 3'b000, 3'b000});
    for (int d = 0; d < 3; d++)
      check($sformatf("reset_data_c%0d", Cols[d]), out_data_w[d], '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Known-answer columns plus fixed points, forward
    st = make_state(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6);
    run_txn(st, 1'b0);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("kat_col0_c%0d", Cols[d]), get_col(got[d], 0), 32'h8e4da1bc);
      check($sformatf("kat_col1_c%0d", Cols[d]), get_col(got[d], 1), 32'h9fdc589d);
      check($sformatf("fix01_fwd_c%0d", Cols[d]), get_col(got[d], 2), 32'h01010101);
      check($sformatf("fixc6_fwd_c%0d", Cols[d]), get_col(got[d], 3), 32'hc6c6c6c6);
    end
    st = make_state(32'hd4d4d4d5, 32'h00000000, 32'hffffffff, 32'h12345678);
    run_txn(st, 1'b0);
    for (int d = 0; d < 3; d++)
      check($sformatf("kat_d4_c%0d", Cols[d]), get_col(got[d], 0), 32'hd5d5d7d6);

    // Known-answer and fixed points, inverse
    st = make_state(32'h8e4da1bc, 32'h01010101, 32'hc6c6c6c6, 32'h9fdc589d);
    run_txn(st, 1'b1);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("kat_inv_col0_c%0d", Cols[d]), get_col(got[d], 0), 32'hdb135345);
      check($sformatf("fix01_inv_c%0d", Cols[d]), get_col(got[d], 1), 32'h01010101);
      check($sformatf("fixc6_inv_c%0d", Cols[d]), get_col(got[d], 2), 32'hc6c6c6c6);
      check($sformatf("kat_inv_col3_c%0d", Cols[d]), get_col(got[d], 3), 32'hf20a225c);
    end

    // Output stall: result must hold and no new state may be taken
    st        = rand128();
    exp_s     = ref_mix(st, 1'b1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = st;
    in_inv    = 1'b1;
    @(negedge clk);
    repeat (6) begin
      in_data = rand128();
      in_inv  = 1'($urandom);
      @(negedge clk);
    end
    for (int i = 0; i < 10; i++) begin
      in_data = rand128();
      in_inv  = 1'($urandom);
      @(negedge clk);
      check("stall_ctrl", {out_valid_w, in_ready_w}, {3'b111, 3'b000});
      for (int d = 0; d < 3; d++)
        check($sformatf("stall_data_c%0d", Cols[d]), out_data_w[d], exp_s);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    check("stall_release", {in_ready_w, out_valid_w}, {3'b111, 3'b000});

    // Reset one edge into processing
    in_valid = 1'b1;
    in_data  = rand128();
    in_inv   = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", {in_ready_w, out_valid_w, busy_w}, {3'b111, 3'b000, 3'b000});
    for (int d = 0; d < 3; d++)
      check($sformatf("midrst_data_c%0d", Cols[d]), out_data_w[d], '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(rand128(), 1'b1);

    // Random forward-then-inverse round trips
    for (int i = 0; i < 1000; i++) begin
      st = rand128();
      run_txn(st, 1'b0);
      fwd = got[0];
      run_txn(fwd, 1'b1);
      for (int d = 0; d < 3; d++)
        check($sformatf("roundtrip_c%0d", Cols[d]), got[d], st);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
